// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadow-latched digit codes,
// refresh prescaler and a one-cycle anti-ghosting blank between digits.
// Optional blink support is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV        = 50000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      load,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp_out
`ifdef SEG_SCAN_BLINK_EN
   ,
   input  logic [NUM_DIGITS-1:0]     blink
`endif
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned DW = 4 * NUM_DIGITS;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   state_e                state_q;
   logic [PW-1:0]         presc_q;
   logic [IW-1:0]         idx_q;
   logic [3:0]            slot_code_q;
   logic                  slot_dp_q;
   logic [DW-1:0]         shadow_digits_q;
   logic [NUM_DIGITS-1:0] shadow_dp_q;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_out_q, dp_out_d;
   logic                  tick_c;
   logic                  wrap_c;

   assign tick_c = (state_q == ST_DRIVE) && (presc_q == PW'(DIV - 1));
   assign wrap_c = (idx_q == IW'(NUM_DIGITS - 1));

   // Active-low glyphs {g,f,e,d,c,b,a}; code 10 is blank, 11..15 show a dash.
   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         4'd10:   s = 7'h7F;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

`ifdef SEG_SCAN_BLINK_EN
   logic [5:0] wrap_cnt_q;

   // Counts completed scans; the MSB toggles the blink phase every 32 scans.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_cnt_q <= 6'd0;
      end else if (tick_c && wrap_c) begin
         wrap_cnt_q <= wrap_cnt_q + 6'd1;
      end
   end
`endif

   // Output values for the next cycle, derived from the current state and slot.
   always_comb begin
      an_d     = {NUM_DIGITS{1'b1}};
      seg_d    = 7'h7F;
      dp_out_d = 1'b1;
      if (state_q == ST_DRIVE) begin
         an_d     = ~(NUM_DIGITS'(1) << idx_q);
         seg_d    = decode(slot_code_q);
         dp_out_d = ~slot_dp_q;
`ifdef SEG_SCAN_BLINK_EN
         if (wrap_cnt_q[5] && blink[idx_q]) begin
            seg_d    = 7'h7F;
            dp_out_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_digits_q <= {NUM_DIGITS{4'd10}};
         shadow_dp_q     <= '0;
      end else if (load) begin
         shadow_digits_q <= digits;
         shadow_dp_q     <= dp;
      end
   end

   // Scan FSM: one BLANK cycle captures the slot, then DIV cycles of DRIVE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BLANK;
         presc_q     <= '0;
         idx_q       <= '0;
         slot_code_q <= 4'd10;
         slot_dp_q   <= 1'b0;
         an_q        <= {NUM_DIGITS{1'b1}};
         seg_q       <= 7'h7F;
         dp_out_q    <= 1'b1;
      end else begin
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_out_q <= dp_out_d;
         case (state_q)
            ST_BLANK: begin
               state_q     <= ST_DRIVE;
               presc_q     <= '0;
               slot_code_q <= shadow_digits_q[4*idx_q +: 4];
               slot_dp_q   <= shadow_dp_q[idx_q];
            end
            default: begin
               if (tick_c) begin
                  state_q <= ST_BLANK;
                  presc_q <= '0;
                  idx_q   <= wrap_c ? '0 : idx_q + IW'(1);
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
         endcase
      end
   end

   assign an     = an_q;
   assign seg    = seg_q;
   assign dp_out = dp_out_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random loads, checked
// against a scan-position model derived from the cycle count since reset release.
module tb_seg_scan_driver;

   localparam int unsigned N      = 4;
   localparam int unsigned DIV    = 4;
   localparam int unsigned SLOT   = DIV + 1;
   localparam int unsigned PERIOD = N * SLOT;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        load;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_out;

   int n_assert = 0;
   int n_fail   = 0;

   int unsigned k;
   logic [3:0]  m_sh   [N];
   logic        m_shdp [N];
   logic [3:0]  m_code;
   logic        m_dp;
   logic [6:0]  glyph  [16];
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   seg_scan_driver #(.NUM_DIGITS(N), .DIV(DIV)) dut (
      .clk    (clk),
      .reset  (reset),
      .digits (digits),
      .dp     (dp),
      .load   (load),
      .an     (an),
      .seg    (seg),
      .dp_out (dp_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   function automatic int unsigned pos();
      return (k - 1) % PERIOD;
   endfunction

   // One clock edge of the reference model: position in the scan decides the output.
   task automatic model_edge();
      int unsigned p, s, r;
      k++;
      p = (k - 1) % PERIOD;
      s = p / SLOT;
      r = p % SLOT;
      if (r == 0) begin
         m_code = m_sh[s];
         m_dp   = m_shdp[s];
         e_an   = 4'hF;
         e_seg  = 7'h7F;
         e_dp   = 1'b1;
      end else begin
         e_an   = ~(4'b0001 << s);
         e_seg  = glyph[m_code];
         e_dp   = ~m_dp;
      end
      if (load) begin
         for (int i = 0; i < N; i++) begin
            m_sh[i]   = digits[4*i +: 4];
            m_shdp[i] = dp[i];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("an", 16'(an), 16'(e_an));
      check("seg", 16'(seg), 16'(e_seg));
      check("dp_out", 16'(dp_out), 16'(e_dp));
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      digits = d;
      dp     = p;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_an"}, 16'(an), 16'hF);
      check({tag, "_seg"}, 16'(seg), 16'h7F);
      check({tag, "_dp"}, 16'(dp_out), 16'h1);
   endtask

   task automatic reset_seq(input int cycles);
      reset = 1'b1;
      #1;
      check_idle("rst_async");
      repeat (cycles) begin
         @(posedge clk);
         #1;
         check_idle("rst_hold");
      end
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         m_sh[i]   = 4'd10;
         m_shdp[i] = 1'b0;
      end
      m_code = 4'd10;
      m_dp   = 1'b0;
   endtask

   task automatic seek(input int unsigned target);
      for (int g = 0; g < int'(PERIOD) + 1 && pos() != target; g++) step();
      check("seek", 16'(pos()), 16'(target));
   endtask

   initial begin
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h10 ^ 7'h10, 7'h10, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      reset  = 1'b1;
      load   = 1'b0;
      digits = 16'h0;
      dp     = 4'h0;
      k      = 0;
      #2;

      // Reset and first driven slot
      reset_seq(10);
      step();
      check("first_blank_an", 16'(an), 16'hF);
      step();
      check("first_drive_an", 16'(an), 16'hE);
      check("first_drive_seg", 16'(seg), 16'h7F);

      // 1234 with dp on digit 0
      do_load(16'h1234, 4'b0001);
      seek(1);
      check("d0_an", 16'(an), 16'hE);
      check("d0_seg", 16'(seg), 16'h19);
      check("d0_dp", 16'(dp_out), 16'h0);
      repeat (PERIOD) step();

      // Mixed glyphs: blank, dash, zero, five
      do_load(16'hAC05, 4'b0000);
      repeat (2 * PERIOD) step();

      // Load during digit 1's slot must not tear the digit being driven
      do_load(16'h1234, 4'b0000);
      seek(SLOT + 1);
      check("d1_seg_before", 16'(seg), 16'h30);
      do_load(16'h9999, 4'b0000);
      repeat (DIV - 1) begin
         check("d1_hold", 16'(seg), 16'h30);
         step();
      end
      repeat (2 * PERIOD) step();

      // Random loads at random times
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'($urandom));
         else step();
      end

      // Reset in the middle of digit 2's drive
      seek(2 * SLOT + 2);
      #1;
      reset_seq(3);
      repeat (2 * PERIOD) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment display driver. It sits directly downstream of the two-digit binary-to-decimal converters.
- Consumes packed 4-bit digit codes: 0-9 are glyphs, 10 means blank (leading-zero suppressed).
- Drives one shared segment bus plus per-digit anodes. Uses a refresh prescaler, a one-cycle anti-ghosting blank between digits, and shadow-latched inputs so the display does not tear.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- DIV, 50000, clock cycles each digit is driven per scan slot; must be ≥2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- digits  input  4*NUM_DIGITS  packed codes; digits[4i+3:4i] is digit i; digit 0 is rightmost.
- dp  input  NUM_DIGITS  decimal-point request per digit, active-high.
- load  input  1  single-cycle strobe; captures digits and dp into the shadow registers.
- an  output  NUM_DIGITS  anode enables, active-low, one-hot-low while driving.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal-point segment, active-low.

Behaviour:
- Reset values (asynchronous, immediate):
  - an all 1, seg 7'h7F, dp_out 1.
  - Shadow digit codes all 10, shadow dp all 0.
  - Slot register = 10, prescaler 0, index 0, state BLANK.
- Shadow: on the clock edge where load=1, shadow_digits<=digits and shadow_dp<=dp. If load=0, the shadow holds.
- State machine:
  - BLANK: always lasts exactly 1 cycle. Transitions to DRIVE. On that transition: prescaler<=0; the slot code and slot dp are captured from shadow[index].
  - DRIVE: prescaler increments each cycle; tick = (prescaler==DIV-1). On tick, index<=(index==NUM_DIGITS-1)?0:index+1 and the state goes to BLANK.
  - Each DRIVE slot lasts exactly DIV cycles. Full scan period = NUM_DIGITS*(DIV+1) cycles.
- Outputs are registered; they reflect the state, index and slot register of the previous cycle.
  - BLANK: an all 1, seg 7'h7F, dp_out 1.
  - DRIVE: an[index]=0 and all other anodes 1; seg=decode(slot code); dp_out=~slot dp.
- Decode table (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10 = 7F (blank; the anode is still asserted).
  - 11..15 = 3F (dash, segment g only).
- Load timing: a load at any time, including the tick or BLANK cycle, updates the shadow only. The digit currently being driven is unchanged. The new value is shown from the next BLANK->DRIVE capture for each digit.
- Reset mid-operation: outputs go inactive at once. After release, the scan restarts at BLANK with index 0, and all digits show blank until a load.
- After reset release, the first DRIVE output appears at the 2nd rising edge.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- When defined:
  - Adds input blink [NUM_DIGITS-1:0].
  - Adds a 6-bit wrap counter that increments each time index wraps to 0. Its MSB is the blink phase (on for 32 scans, off for 32 scans; the counter resets to 0).
  - While the phase is 1, a DRIVE slot whose digit has blink[index]=1 outputs seg 7'h7F and dp_out 1. The anode still follows normal behaviour.
  - blink is sampled live, not shadowed.
- When undefined: no blink port and no counter; behaviour is exactly as above.

Test Plan (all scenarios NUM_DIGITS=4, DIV=4):
- Reset held 10 cycles then released -> an=4'b1111, seg=7'h7F, dp_out=1 throughout reset; first driven output 2 edges after release, with an=4'b1110, seg=7'h7F (shadow blank).
- load with digits=16'h1234, dp=4'b0001 -> digit0 slot: an=1110, seg=7'h19, dp_out=0; digit1: an=1101, seg=7'h30; digit2: 7'h24; digit3: an=0111, seg=7'h79.
- Scan timing -> each anode low exactly 4 cycles, separated by 1 cycle of an=4'b1111; digit0 recurs every 20 cycles; index wraps 3->0.
- digits=16'hAC05 -> digit0 7'h12, digit1 7'h40, digit2 7'h3F, digit3 7'h7F with an[3]=0.
- load 16'h9999 pulsed during the 2nd cycle of digit1's slot showing 3 -> seg stays 7'h30 to slot end; digit2 slot shows 7'h10; digit1 shows 7'h10 on the next scan.
- reset asserted mid-DRIVE of digit2 -> an=4'b1111 in the same cycle without waiting for a clock edge; after release, digit0 is driven first with blank segments.
